// File: rtl/systolic_ctrl.sv
// Sequencer for one matrix-multiply pass: clear C, load A rows, run the array
// for 3*DIM-2 cycles plus a settle cycle, then unload C rows over valid/ready.
module systolic_ctrl #(
    parameter int DIM     = 8,
    parameter int ROWBITS = $clog2(DIM),
    parameter int CNTBITS = $clog2(3*DIM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               a_valid,
    output logic               a_ready,
    output logic               a_wr_en,
    output logic [ROWBITS-1:0] a_row,
    output logic               c_clr,
    output logic               mem_en,
    output logic               sa_en,
    output logic [ROWBITS-1:0] c_row,
    output logic               c_valid,
    input  logic               c_ready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COMPUTE, READ, DONE} state_t;

    localparam logic [ROWBITS-1:0] LAST_ROW = ROWBITS'(DIM-1);
    localparam logic [CNTBITS-1:0] LAST_CYC = CNTBITS'(3*DIM-3);
    localparam logic [CNTBITS-1:0] SETTLE   = CNTBITS'(3*DIM-2);

    state_t             state, nxt;
    logic [ROWBITS-1:0] row_cnt, nxt_row;
    logic [CNTBITS-1:0] cyc_cnt, nxt_cyc;

    assign a_wr_en = a_valid & a_ready;

    always_comb begin
        nxt     = state;
        nxt_row = row_cnt;
        nxt_cyc = cyc_cnt;
        case (state)
            IDLE: if (start) begin
                nxt     = CLEAR;
                nxt_row = '0;
                nxt_cyc = '0;
            end
            CLEAR: begin
                nxt     = LOAD;
                nxt_row = '0;
            end
            LOAD: if (a_valid) begin
                if (row_cnt == LAST_ROW) begin
                    nxt     = COMPUTE;
                    nxt_row = '0;
                    nxt_cyc = '0;
                end else begin
                    nxt_row = row_cnt + ROWBITS'(1);
                end
            end
            // cyc_cnt == SETTLE is the idle settle cycle before unloading
            COMPUTE: if (cyc_cnt == SETTLE) begin
                nxt     = READ;
                nxt_row = '0;
            end else begin
                nxt_cyc = cyc_cnt + CNTBITS'(1);
            end
            READ: if (c_ready) begin
                if (row_cnt == LAST_ROW) nxt = DONE;
                else                     nxt_row = row_cnt + ROWBITS'(1);
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            row_cnt <= '0;
            cyc_cnt <= '0;
            a_ready <= 1'b0;
            a_row   <= '0;
            c_clr   <= 1'b0;
            mem_en  <= 1'b0;
            sa_en   <= 1'b0;
            c_row   <= '0;
            c_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nxt;
            row_cnt <= nxt_row;
            cyc_cnt <= nxt_cyc;
            a_ready <= (nxt == LOAD);
            a_row   <= (nxt == LOAD) ? nxt_row : '0;
            c_clr   <= (nxt == CLEAR);
            mem_en  <= (nxt == COMPUTE) && (nxt_cyc <= LAST_CYC);
            sa_en   <= (nxt == COMPUTE) && (nxt_cyc <= LAST_CYC);
            c_row   <= (nxt == READ) ? nxt_row : '0;
            c_valid <= (nxt == READ);
            busy    <= (nxt != IDLE);
            done    <= (nxt == DONE);
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (DIM=8): nominal pass, load stall, read
// backpressure, ignored start, and asynchronous reset mid-compute.
module tb_systolic_ctrl;

    localparam int DIM = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_wr_en, c_clr, mem_en, sa_en, c_valid, busy, done;
    logic [2:0] a_row, c_row;
    logic       c_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    int busy_n, clr_n, clr_k, mem_n, sa_n, mem_first, wr_n, rd_n, done_n, done_k;
    int a_hold, c_hold;
    int wr_rows[16];
    int rd_rows[16];

    always #5 clk = ~clk;

    systolic_ctrl #(.DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_valid(a_valid), .a_ready(a_ready), .a_wr_en(a_wr_en), .a_row(a_row),
        .c_clr(c_clr), .mem_en(mem_en), .sa_en(sa_en),
        .c_row(c_row), .c_valid(c_valid), .c_ready(c_ready),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one pass for ncyc cycles; k=1 is the first cycle after the edge that sees start.
    task automatic run(input int ncyc, input int a_st, input int a_gap_in, input int c_st,
                       input int c_gap_in, input int ign_k, input bit inj_done, input int rst_k);
        int a_gap = a_gap_in;
        int c_gap = c_gap_in;
        busy_n = 0; clr_n = 0; clr_k = -1; mem_n = 0; sa_n = 0; mem_first = -1;
        wr_n = 0; rd_n = 0; done_n = 0; done_k = -1; a_hold = 0; c_hold = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = (k == ign_k) || (inj_done && done);
            if (a_ready && a_row == 3'(a_st) && a_gap > 0) begin a_valid = 1'b0; a_gap--; end
            else a_valid = 1'b1;
            if (c_valid && c_row == 3'(c_st) && c_gap > 0) begin c_ready = 1'b0; c_gap--; end
            else c_ready = 1'b1;
            #1;
            if (busy) busy_n++;
            if (c_clr) begin clr_n++; if (clr_k < 0) clr_k = k; end
            if (mem_en) begin mem_n++; if (mem_first < 0) mem_first = k; end
            if (sa_en) sa_n++;
            if (a_wr_en) begin if (wr_n < 16) wr_rows[wr_n] = int'(a_row); wr_n++; end
            if (a_ready && !a_valid && a_row == 3'(a_st)) a_hold++;
            if (c_valid && c_ready) begin if (rd_n < 16) rd_rows[rd_n] = int'(c_row); rd_n++; end
            if (c_valid && !c_ready && c_row == 3'(c_st)) c_hold++;
            if (done) begin done_n++; if (done_k < 0) done_k = k; end
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_mem_en", 32'(mem_en), 0);
                chk("rst_mid_sa_en", 32'(sa_en), 0);
                chk("rst_mid_busy", 32'(busy), 0);
            end
        end
        start = 1'b0;
    endtask

    task automatic chk_rows(input string tag);
        for (int i = 0; i < DIM; i++) begin
            chk({tag, "_a_row"}, 32'(wr_rows[i]), 32'(i));
            chk({tag, "_c_row"}, 32'(rd_rows[i]), 32'(i));
        end
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", {19'd0, a_ready, a_wr_en, a_row, c_clr, mem_en, sa_en, c_row,
                              c_valid, busy, done}, 0);
        end

        // Nominal pass
        run(45, -1, 0, -1, 0, -1, 1'b0, -1);
        chk("nom_clr_n", clr_n, 1);
        chk("nom_clr_k", clr_k, 1);
        chk("nom_wr_n", wr_n, 8);
        chk("nom_mem_n", mem_n, 22);
        chk("nom_sa_n", sa_n, 22);
        chk("nom_mem_first", mem_first, 10);
        chk("nom_rd_n", rd_n, 8);
        chk("nom_done_n", done_n, 1);
        chk("nom_done_k", done_k, 41);
        chk("nom_busy_n", busy_n, 41);
        chk_rows("nom");

        // Load stall at row 4 for 3 cycles
        run(50, 4, 3, -1, 0, -1, 1'b0, -1);
        chk("lst_a_hold", a_hold, 3);
        chk("lst_wr_n", wr_n, 8);
        chk("lst_mem_first", mem_first, 13);
        chk("lst_mem_n", mem_n, 22);
        chk("lst_done_k", done_k, 44);
        chk("lst_busy_n", busy_n, 44);
        chk_rows("lst");

        // Read backpressure at row 2 for 5 cycles
        run(52, -1, 0, 2, 5, -1, 1'b0, -1);
        chk("rbp_c_hold", c_hold, 5);
        chk("rbp_rd_n", rd_n, 8);
        chk("rbp_done_k", done_k, 46);
        chk("rbp_busy_n", busy_n, 46);
        chk_rows("rbp");

        // start during COMPUTE and DONE is ignored
        run(60, -1, 0, -1, 0, 15, 1'b1, -1);
        chk("ign_clr_n", clr_n, 1);
        chk("ign_busy_n", busy_n, 41);
        chk("ign_done_n", done_n, 1);
        chk("ign_idle_busy", 32'(busy), 0);

        // Async reset with cyc_cnt=10 (k=20), then a full pass
        run(25, -1, 0, -1, 0, -1, 1'b0, 20);
        chk("rst_mem_n", mem_n, 11);
        chk("rst_done_n", done_n, 0);
        rst_n = 1'b1;
        run(45, -1, 0, -1, 0, -1, 1'b0, -1);
        chk("post_clr_k", clr_k, 1);
        chk("post_mem_n", mem_n, 22);
        chk("post_done_k", done_k, 41);
        chk("post_busy_n", busy_n, 41);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencing controller for one matrix-multiply pass of the DIM x DIM systolic array. It loads A rows into memA and clears the C accumulators. It then asserts the memA/memB/array enables for exactly 3*DIM-2 compute cycles, and unloads the DIM result rows of C over a valid/ready handshake. It sits between the host-side load/unload logic and the memA, memB and systolic_array instances.

Parameters:
DIM, 8, array dimension (rows = cols); must be >= 2.
ROWBITS, $clog2(DIM), width of row indices.
CNTBITS, $clog2(3*DIM), width of the cycle counter.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a pass; sampled only in IDLE.
a_valid  input  1  host presents an A row this cycle.
a_ready  output  1  controller accepts an A row (LOAD state).
a_wr_en  output  1  memA write enable = a_valid & a_ready.
a_row  output  ROWBITS  memA row index being written.
c_clr  output  1  one-cycle clear of all C accumulators (array WrEn with zero data).
mem_en  output  1  shift enable to memA and memB.
sa_en  output  1  systolic array compute enable.
c_row  output  ROWBITS  C row index presented to array read port (Crow).
c_valid  output  1  C row at c_row is valid for the host.
c_ready  input  1  host consumes the C row.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at end of pass.

Behaviour:
- States: IDLE, CLEAR, LOAD, COMPUTE, READ, DONE. Moore outputs decoded from state and counters; a_wr_en is the only output that depends on an input.
- Reset (async, any state): state=IDLE, row_cnt=0, cyc_cnt=0. All outputs 0; a_row=0, c_row=0.
- IDLE: start=1 -> CLEAR next cycle. start=0 -> stay.
- CLEAR: c_clr=1 for exactly one cycle -> LOAD; row_cnt=0.
- LOAD: a_ready=1 and a_row=row_cnt.
  - When a_valid=1: row_cnt increments.
  - The write with row_cnt=DIM-1 -> COMPUTE with cyc_cnt=0.
  - a_valid=0 stalls with no write and no count change, for any duration.
- COMPUTE: mem_en=1 and sa_en=1 for exactly 3*DIM-2 consecutive cycles (cyc_cnt 0..3*DIM-3).
  - After the last compute cycle, spend one settle cycle with mem_en=sa_en=0, then -> READ with row_cnt=0.
- READ: c_valid=1 and c_row=row_cnt.
  - c_ready=1 consumes the row and increments row_cnt. Consuming row DIM-1 -> DONE.
  - c_ready=0 holds c_row and c_valid stable.
- DONE: done=1 for one cycle -> IDLE. busy=0 from the IDLE cycle onward.
- start while busy (any non-IDLE state, including DONE): ignored; it is not queued.
- Counters never wrap in normal operation. row_cnt saturates logically at DIM-1 via the state transitions.
- Reset asserted mid-operation: immediate return to IDLE with all enables low. A subsequent start runs a full pass including CLEAR.
- Cycle count for a pass with no stalls, start seen at edge 0: CLEAR 1 + LOAD DIM + COMPUTE 3*DIM-2 + settle 1 + READ DIM + DONE 1. For DIM=8 that is 41 cycles of busy.

Test Plan:
- Reset: rst_n=0 then release, no start -> all outputs 0, state IDLE, busy=0 for 10 cycles.
- Full pass, DIM=8, a_valid and c_ready tied high -> c_clr single pulse; 8 a_wr_en cycles with a_row 0..7; mem_en=sa_en high exactly 22 cycles; c_row 0..7 with c_valid; done pulse; busy high 41 cycles.
- Load stall: a_valid low for 3 cycles after row 4 -> a_row holds 4, no a_wr_en during the gap, COMPUTE entry delayed exactly 3 cycles.
- Read backpressure: c_ready low for 5 cycles at c_row=2 -> c_row=2 and c_valid=1 held stable, done delayed 5 cycles.
- start pulsed during COMPUTE and during DONE -> ignored; IDLE reached and no second pass begins.
- rst_n asserted asynchronously mid-COMPUTE (cyc_cnt=10) -> mem_en/sa_en drop immediately; next start runs a full 41-cycle pass from CLEAR.
